mux3_rr_arbiter: RTL and testbench
==================================

Name: mux3_rr_arbiter

Overview:
Round-robin arbiter that shares one 3:1 multiplexer (inputs A, B, C; 2-bit select S) among three requesters. It drives the mux select and a one-hot grant vector. It also enforces a bounded hold time, so that one requester cannot hold the mux indefinitely while others wait. It sits directly in front of the MUX3 instance, and its S output wires straight to the mux select.

Parameters:
MAX_HOLD, 4, max consecutive grant cycles for one owner while another request is pending; legal range 1..15; internal hold counter sized to hold MAX_HOLD.

Ports:
clk  input  1  system clock, rising-edge active
rst_n  input  1  asynchronous, active-low reset
REQ  input  3  request vector; bit0=A, bit1=B, bit2=C; level-sensitive, held by requester while it needs the mux
GNT  output  3  one-hot grant (or 000 when idle); registered
S  output  2  mux select to MUX3; A=00, B=01, C=10; 11 never driven; registered
VALID  output  1  1 when a grant is active (mux output Y is owned); registered
PREEMPT  output  1  one-cycle pulse on the edge where an owner is forcibly rotated out by hold expiry; registered

Behaviour:
- One clock (clk). Reset is asynchronous, active-low (rst_n). All state and outputs clear immediately on rst_n=0, independent of clk.
- Reset values:
  - Outputs: GNT=000, S=00, VALID=0, PREEMPT=0.
  - Internal: state=IDLE, round-robin pointer PTR=0 (A first), hold counter CNT=0.
- Search order from index k: k, k+1, k+2, all mod 3. The first set REQ bit wins.
- Latency: a request seen at edge N produces a grant at edge N+1. There is no combinational path from REQ to any output.
- IDLE:
  - REQ=000: stay in IDLE, all outputs hold.
  - Otherwise: grant the winner of a search from PTR. Set GNT, S and VALID=1, CNT=1, go to GRANT.
- GRANT, owner i, evaluated each edge in priority order:
  1. REQ[i]=0 (release):
     - PTR=i+1 mod 3.
     - If any other REQ bit is set: grant the winner of a search from i+1 on this same edge (no idle bubble), CNT=1, PREEMPT=0.
     - Else: GNT=000, VALID=0, go to IDLE.
  2. REQ[i]=1, CNT==MAX_HOLD, another REQ bit set (preempt):
     - Grant the winner of a search from i+1, PTR=i+1 mod 3, CNT=1, PREEMPT=1 for exactly this cycle.
  3. REQ[i]=1, CNT==MAX_HOLD, no other request: keep the grant. CNT saturates at MAX_HOLD, with no wrap-around. Preemption occurs at the first edge a competitor appears.
  4. Otherwise: keep the grant, CNT=CNT+1.
- PREEMPT is 0 on every edge where rule 2 does not fire.
- S when VALID=0: holds the last granted value so the mux output stays stable. After reset it is 00.
- Invariants:
  - GNT is always one-hot or zero.
  - VALID == |GNT.
  - S always matches the GNT encoding when VALID=1.
- MAX_HOLD=1: under contention, ownership rotates every cycle.
- Request withdrawn by a non-owner before it is granted: it is ignored, with no side effects.
- Reset asserted mid-grant: outputs clear asynchronously. After release, arbitration restarts from PTR=0.
- Expected implementation size: 150-250 lines.

Test Plan:
1. Reset: hold rst_n=0 with REQ=111 for 3 edges -> GNT=000, S=00, VALID=0, PREEMPT=0 throughout.
2. Single grant: after reset, REQ=010 before edge 1 -> edge 1: GNT=010, S=01, VALID=1. Then drop REQ to 000 -> next edge: GNT=000, VALID=0, S stays 01.
3. Full contention, MAX_HOLD=4: REQ=111 held from IDLE with PTR=0 -> GNT sequence 001 for 4 cycles, 010 for 4, 100 for 4, then 001. S follows 00, 01, 10. PREEMPT=1 for one cycle at each switch.
4. Back-to-back release: owner A (GNT=001) with REQ=111; drop REQ[0] at CNT=2 -> next edge GNT=010, S=01, VALID stays 1, PREEMPT=0.
5. Saturation: REQ=100 alone for 10 cycles -> GNT=100, S=10 held, PREEMPT=0. Then raise REQ[0] -> next edge GNT=001, PREEMPT=1.
6. Mid-grant reset: GNT=010, pulse rst_n low between edges -> GNT=000, VALID=0 before the next edge. Release rst_n with REQ=110 -> first grant GNT=010 (search from PTR=0).

Source files
------------

// File: rtl/mux3_rr_arbiter.sv
// Round-robin arbiter for a shared 3:1 mux: drives one-hot grant and mux select,
// rotating the owner out once it has held the mux MAX_HOLD cycles under contention.
module mux3_rr_arbiter #(
  parameter int unsigned MAX_HOLD = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] REQ,
  output logic [2:0] GNT,
  output logic [1:0] S,
  output logic       VALID,
  output logic       PREEMPT
);

  localparam int unsigned CW = $clog2(MAX_HOLD + 1);
  localparam logic [CW-1:0] HOLD_LIM = CW'(MAX_HOLD);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  state_t        state_q, state_d;
  logic [1:0]    ptr_q, ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    gnt_q, gnt_d;
  logic [1:0]    sel_q, sel_d;
  logic          valid_q, valid_d;
  logic          preempt_q, preempt_d;

  logic [1:0]    pick_ptr;
  logic [1:0]    pick_next;
  logic [1:0]    owner_next;
  logic          owner_req;
  logic          other_req;

  // First set request bit scanning start, start+1, start+2 (mod 3).
  function automatic logic [1:0] rr_pick(input logic [2:0] req, input logic [1:0] start);
    logic [1:0] idx;
    logic       hit;
    rr_pick = '0;
    hit     = 1'b0;
    for (int unsigned j = 0; j < 3; j++) begin
      idx = 2'((32'(start) + j) % 3);
      if (!hit && req[idx]) begin
        rr_pick = idx;
        hit     = 1'b1;
      end
    end
  endfunction

  function automatic logic [1:0] inc3(input logic [1:0] i);
    inc3 = (i == 2'd2) ? 2'd0 : i + 2'd1;
  endfunction

  function automatic logic [2:0] onehot(input logic [1:0] i);
    onehot = 3'(3'b001 << i);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      cnt_q     <= '0;
      gnt_q     <= '0;
      sel_q     <= '0;
      valid_q   <= 1'b0;
      preempt_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      gnt_q     <= gnt_d;
      sel_q     <= sel_d;
      valid_q   <= valid_d;
      preempt_q <= preempt_d;
    end
  end

  // In GRANT, sel_q is the owner index; the search past it puts the owner last,
  // so it is only re-picked when nobody else is requesting.
  always_comb begin
    owner_next = inc3(sel_q);
    pick_ptr   = rr_pick(REQ, ptr_q);
    pick_next  = rr_pick(REQ, owner_next);
    owner_req  = |(REQ & gnt_q);
    other_req  = |(REQ & ~gnt_q);

    state_d   = state_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    gnt_d     = gnt_q;
    sel_d     = sel_q;
    valid_d   = valid_q;
    preempt_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (|REQ) begin
          gnt_d   = onehot(pick_ptr);
          sel_d   = pick_ptr;
          valid_d = 1'b1;
          cnt_d   = CNT_ONE;
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (!owner_req) begin
          ptr_d = owner_next;
          if (other_req) begin
            gnt_d = onehot(pick_next);
            sel_d = pick_next;
            cnt_d = CNT_ONE;
          end else begin
            gnt_d   = '0;
            valid_d = 1'b0;
            state_d = IDLE;
          end
        end else if (cnt_q == HOLD_LIM) begin
          if (other_req) begin
            gnt_d     = onehot(pick_next);
            sel_d     = pick_next;
            ptr_d     = owner_next;
            cnt_d     = CNT_ONE;
            preempt_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    GNT     = gnt_q;
    S       = sel_q;
    VALID   = valid_q;
    PREEMPT = preempt_q;
  end

endmodule

// File: tb/tb_mux3_rr_arbiter.sv
// Self-checking bench for mux3_rr_arbiter: per-cycle model comparison plus
// directed vectors with hand-computed expectations.
module tb_mux3_rr_arbiter;

  localparam int unsigned HOLD = 4;

  logic       clk;
  logic       rst_n;
  logic [2:0] REQ;
  logic [2:0] GNT;
  logic [1:0] S;
  logic       VALID;
  logic       PREEMPT;

  int checks = 0;
  int errors = 0;

  mux3_rr_arbiter #(.MAX_HOLD(HOLD)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .REQ    (REQ),
    .GNT    (GNT),
    .S      (S),
    .VALID  (VALID),
    .PREEMPT(PREEMPT)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: owner index (-1 = idle), pointer, hold count.
  int         m_owner = -1;
  int         m_ptr   = 0;
  int         m_cnt   = 0;
  logic [1:0] m_s     = 2'b00;
  bit         m_pre   = 1'b0;

  function automatic int search(input logic [2:0] r, input int k);
    for (int j = 0; j < 3; j++) begin
      if (r[(k + j) % 3]) return (k + j) % 3;
    end
    return -1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_owner = -1;
      m_ptr   = 0;
      m_cnt   = 0;
      m_s     = 2'b00;
      m_pre   = 1'b0;
    end else begin
      int others;
      m_pre = 1'b0;
      if (m_owner < 0) begin
        m_owner = search(REQ, m_ptr);
        m_cnt   = 1;
      end else begin
        others = int'(REQ) & ~(1 << m_owner) & 7;
        if (!REQ[m_owner]) begin
          m_ptr   = (m_owner + 1) % 3;
          m_owner = search(REQ, m_ptr);
          m_cnt   = 1;
        end else if (m_cnt >= HOLD && others != 0) begin
          m_ptr   = (m_owner + 1) % 3;
          m_owner = search(REQ, m_ptr);
          m_cnt   = 1;
          m_pre   = 1'b1;
        end else if (m_cnt < HOLD) begin
          m_cnt++;
        end
      end
      if (m_owner >= 0) m_s = 2'(m_owner);
    end
  end

  always @(negedge clk) begin
    logic [2:0] eg;
    eg = (m_owner < 0) ? 3'b000 : 3'(1 << m_owner);
    chk("model_gnt", 32'(GNT), 32'(eg));
    chk("model_s", 32'(S), 32'(m_s));
    chk("model_valid", 32'(VALID), 32'(m_owner >= 0));
    chk("model_preempt", 32'(PREEMPT), 32'(m_pre));
  end

  task automatic step(input logic [2:0] r);
    REQ = r;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string name, input logic [2:0] g, input logic [1:0] s,
                            input logic v, input logic p);
    chk({name, "_gnt"}, 32'(GNT), 32'(g));
    chk({name, "_s"}, 32'(S), 32'(s));
    chk({name, "_valid"}, 32'(VALID), 32'(v));
    chk({name, "_preempt"}, 32'(PREEMPT), 32'(p));
  endtask

  task automatic pulse_reset;
    rst_n = 1'b0;
    #1;
    expect_out("rst_async", 3'b000, 2'b00, 1'b0, 1'b0);
    rst_n = 1'b1;
  endtask

  logic [2:0] vec [16] = '{3'b011, 3'b011, 3'b001, 3'b110, 3'b100, 3'b101, 3'b111, 3'b000,
                           3'b010, 3'b111, 3'b111, 3'b111, 3'b111, 3'b111, 3'b001, 3'b000};

  initial begin
    logic [2:0] eg;
    rst_n = 1'b0;
    REQ   = 3'b111;
    // Reset held with all requests asserted.
    repeat (3) begin
      @(posedge clk);
      #1;
      expect_out("reset", 3'b000, 2'b00, 1'b0, 1'b0);
    end
    REQ   = 3'b000;
    rst_n = 1'b1;

    step(3'b010);
    expect_out("single", 3'b010, 2'b01, 1'b1, 1'b0);
    step(3'b000);
    expect_out("single_rel", 3'b000, 2'b01, 1'b0, 1'b0);

    // Full contention from PTR=0.
    pulse_reset();
    for (int c = 1; c <= 13; c++) begin
      step(3'b111);
      eg = (c <= 4) ? 3'b001 : (c <= 8) ? 3'b010 : (c <= 12) ? 3'b100 : 3'b001;
      expect_out("contend", eg, (eg == 3'b001) ? 2'b00 : (eg == 3'b010) ? 2'b01 : 2'b10,
                 1'b1, (c == 5 || c == 9 || c == 13));
    end

    step(3'b111);
    expect_out("b2b_hold", 3'b001, 2'b00, 1'b1, 1'b0);
    step(3'b110);
    expect_out("b2b_rel", 3'b010, 2'b01, 1'b1, 1'b0);

    for (int c = 0; c < 10; c++) begin
      step(3'b100);
      expect_out("saturate", 3'b100, 2'b10, 1'b1, 1'b0);
    end
    step(3'b101);
    expect_out("sat_preempt", 3'b001, 2'b00, 1'b1, 1'b1);

    step(3'b010);
    expect_out("pre_midrst", 3'b010, 2'b01, 1'b1, 1'b0);
    pulse_reset();
    step(3'b110);
    expect_out("post_rst", 3'b010, 2'b01, 1'b1, 1'b0);

    // Mixed vectors, checked by the per-cycle model only.
    for (int i = 0; i < 16; i++) step(vec[i]);

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
